// File: rtl/fwd_pkg.sv
// Shared types and helpers for the E-stage forwarding/hazard unit.
//   tag_t       : per-stage destination tag {v, late, rd}
//   selw()      : width of an operand source select for a given stage count
//   SEL_REGFILE : select value meaning "take the register-file read data"
package fwd_pkg;

  localparam int REGW_DEF    = 5;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                v;
    logic                late;
    logic [REGW_DEF-1:0] rd;
  } tag_t;

  function automatic int selw(input int nstg);
    return $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle of E-stage control/data signals between the pipeline and the
// forwarding unit.
//   master : pipeline side (drives i_*, receives o_*)
//   slave  : forwarding unit side
// Signals:
//   i_con_ev/we/late/rd  E instruction valid, writes rd, result is late, rd
//   i_con_rs             E source registers, NSRC x REGW
//   i_data_rs            register-file read data, NSRC x XLEN
//   i_data_stg           result of stage k at slice k-1, NSTG x XLEN
//   i_con_flush/hold     squash E instruction / freeze the tag pipeline
//   o_data_op            resolved operands, NSRC x XLEN
//   o_con_sel            per-operand source, 0 = regfile, k = stage k
//   o_con_stall          load-use stall request
//   o_con_pend           number of valid writing tags in flight
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = REGW_DEF,
  parameter int NSRC = 2,
  parameter int NSTG = 3
);
  localparam int SELW = selw(NSTG);

  logic                 i_con_ev;
  logic                 i_con_we;
  logic                 i_con_late;
  logic [REGW-1:0]      i_con_rd;
  logic [NSRC*REGW-1:0] i_con_rs;
  logic [NSRC*XLEN-1:0] i_data_rs;
  logic [NSTG*XLEN-1:0] i_data_stg;
  logic                 i_con_flush;
  logic                 i_con_hold;
  logic [NSRC*XLEN-1:0] o_data_op;
  logic [NSRC*SELW-1:0] o_con_sel;
  logic                 o_con_stall;
  logic [SELW-1:0]      o_con_pend;

  modport master (
    output i_con_ev, i_con_we, i_con_late, i_con_rd, i_con_rs,
           i_data_rs, i_data_stg, i_con_flush, i_con_hold,
    input  o_data_op, o_con_sel, o_con_stall, o_con_pend
  );

  modport slave (
    input  i_con_ev, i_con_we, i_con_late, i_con_rd, i_con_rs,
           i_data_rs, i_data_stg, i_con_flush, i_con_hold,
    output o_data_op, o_con_sel, o_con_stall, o_con_pend
  );

endinterface

// File: rtl/fwd_match.sv
// Priority matcher for one source operand against the in-flight tag array.
//   i_tags           : tag of stage k at index k-1 (index 0 = youngest)
//   i_rs             : source register index
//   o_sel            : youngest matching stage, 0 when nothing matches
//   o_hit_late_early : youngest match carries a late result that is not yet
//                      usable at its stage
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NSTG     = 3,
  parameter int LATE_STG = 2,
  parameter int SELW     = selw(NSTG)
) (
  input  tag_t                i_tags [NSTG],
  input  logic [REGW_DEF-1:0] i_rs,
  output logic [SELW-1:0]     o_sel,
  output logic                o_hit_late_early
);

  // Scan from the oldest stage to the youngest so the youngest match is the
  // last assignment; an older non-late match can never mask a younger late one.
  always_comb begin
    o_sel            = SELW'(SEL_REGFILE);
    o_hit_late_early = 1'b0;
    for (int k = NSTG; k >= 1; k--) begin
      if (i_tags[k-1].v && (i_tags[k-1].rd == i_rs) && (i_rs != '0)) begin
        o_sel            = SELW'(k);
        o_hit_late_early = i_tags[k-1].late && (k < LATE_STG);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// E-stage forwarding and load-use hazard unit.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears all in-flight tags
//   bus     : fwd_scoreboard_if slave (E-stage control, operand data,
//             resolved operands, selects, stall and pending count)
// A tag pipeline of NSTG entries mirrors the destination registers of the
// instructions downstream of E. Operand selection and the stall are
// combinational from those tags; only the tags and the pending count are state.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REGW     = REGW_DEF,
  parameter int NSRC     = 2,
  parameter int NSTG     = 3,
  parameter int LATE_STG = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  fwd_scoreboard_if.slave bus
);

  localparam int SELW = selw(NSTG);

  tag_t                 r_tag [NSTG];
  tag_t                 w_tag_nxt [NSTG];
  logic [SELW-1:0]      r_pend;
  logic [SELW-1:0]      w_sel [NSRC];
  logic [NSRC-1:0]      w_haz;
  logic                 w_stall;
  logic                 w_tag1_v;
  logic [NSRC*XLEN-1:0] w_op;
  logic [NSRC*SELW-1:0] w_sel_flat;

  function automatic logic [SELW-1:0] popcnt_v(input tag_t t [NSTG]);
    logic [SELW-1:0] n;
    n = '0;
    for (int k = 0; k < NSTG; k++) n = n + SELW'(t[k].v);
    return n;
  endfunction

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .NSTG     (NSTG),
      .LATE_STG (LATE_STG),
      .SELW     (SELW)
    ) u_match (
      .i_tags           (r_tag),
      .i_rs             (bus.i_con_rs[s*REGW +: REGW]),
      .o_sel            (w_sel[s]),
      .o_hit_late_early (w_haz[s])
    );
  end

  // A squashed instruction never stalls; flush wins over a pending hazard.
  assign w_stall  = bus.i_con_ev & ~bus.i_con_flush & (|w_haz);
  // x0 and non-writing instructions enter as bubbles, as do stalled or
  // flushed ones, so only real producers are ever matched or counted.
  assign w_tag1_v = bus.i_con_ev & bus.i_con_we & (bus.i_con_rd != '0)
                  & ~bus.i_con_flush & ~w_stall;

  always_comb begin
    w_tag_nxt[0] = '{v: w_tag1_v, late: bus.i_con_late, rd: bus.i_con_rd};
    for (int k = 1; k < NSTG; k++) w_tag_nxt[k] = r_tag[k-1];
  end

  always_comb begin
    w_op       = bus.i_data_rs;
    w_sel_flat = '0;
    for (int s = 0; s < NSRC; s++) begin
      w_sel_flat[s*SELW +: SELW] = w_sel[s];
      for (int k = 1; k <= NSTG; k++) begin
        if (w_sel[s] == SELW'(k)) w_op[s*XLEN +: XLEN] = bus.i_data_stg[(k-1)*XLEN +: XLEN];
      end
    end
  end

  // Tag pipeline: hold freezes everything, otherwise shift one stage and the
  // oldest tag retires (the register file already holds its value).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSTG; k++) r_tag[k] <= '0;
      r_pend <= '0;
    end else if (!bus.i_con_hold) begin
      r_tag  <= w_tag_nxt;
      r_pend <= popcnt_v(w_tag_nxt);
    end
  end

  assign bus.o_data_op   = w_op;
  assign bus.o_con_sel   = w_sel_flat;
  assign bus.o_con_stall = w_stall;
  assign bus.o_con_pend  = r_pend;

endmodule
